corefifo_wr_ptr_gen: RTL
========================

// Module: corefifo_wr_ptr_gen
// PURPOSE
//  Write-domain pointer generator and full-flag logic for the dual-clock COREFIFO.
//  Keeps the binary write address and launches the registered Gray write pointer
//  toward the read-domain N-stage synchronizer.
//  Receives the read pointer (Gray, already synchronized into clk) and produces full,
//  optional almost-full, write ack and overflow.
// PARAMETERS
//  ADDRWIDTH  3  RAM address width; pointers are ADDRWIDTH+1 bits; depth 2**ADDRWIDTH; legal >=2
//  AFULL_VAL  6  almost-full threshold in words (1..2**ADDRWIDTH); used only with macro
// PORTS
//  clk         in   1            write clock
//  arstn       in   1            reset, asynchronous, active-low
//  srstn       in   1            synchronous reset, active-low
//  wr_en       in   1            write request
//  rptr_gray_s in   ADDRWIDTH+1  read pointer, Gray, synchronized to clk
//  waddr       out  ADDRWIDTH    RAM write address (binary, low bits of wbin)
//  wptr_gray   out  ADDRWIDTH+1  registered Gray write pointer, to synchronizer
//  we_ram      out  1            RAM write strobe = wr_en & ~full (combinational)
//  full        out  1            FIFO full, registered
//  afull       out  1            almost full, registered (tied 0 without macro)
//  wr_ack      out  1            one-cycle pulse, write accepted last cycle
//  overflow    out  1            one-cycle pulse, write rejected last cycle
// BEHAVIOUR
//  - Reset (!arstn async, or !srstn at clk edge): wbin=0, wptr_gray=0, full=0,
//    afull=0, wr_ack=0, overflow=0. Same priority as arstn; srstn wins over wr_en.
//  - Accept: we_ram = wr_en & ~full. On accept wbin_nxt = wbin+1 (mod 2**(ADDRWIDTH+1)),
//    else wbin_nxt = wbin. waddr = wbin[ADDRWIDTH-1:0] (current, pre-increment).
//  - wptr_gray <= wbin_nxt ^ (wbin_nxt>>1); changes by exactly one bit per accept;
//    never driven from combinational logic (CDC-safe launch register).
//  - full <= (gray(wbin_nxt) == {~rptr_gray_s[A:A-1], rptr_gray_s[A-2:0]}), A=ADDRWIDTH.
//    Full asserts the cycle after the accept that fills the FIFO; deasserts one clk
//    after rptr_gray_s advances (plus sync latency upstream -> pessimistic, never late).
//  - wr_ack <= we_ram; overflow <= wr_en & full. Never both high.
//  - Wrap: wbin wraps 2**(A+1)-1 -> 0; MSB toggle distinguishes full from empty.
//  - Simultaneous write and read-pointer advance while full: write rejected (full is
//    registered); full clears next cycle.
//  - rptr_gray_s is treated as quasi-static: only value comparison, no edge logic.
// CONFIGURATION
//  Macro COREFIFO_AFULL_EN:
//   defined:  wcnt = wbin_nxt - gray2bin(rptr_gray_s) (A+1 bits, modular);
//             afull <= (wcnt >= AFULL_VAL); asserted with or before full.
//   undefined: no gray2bin/subtractor logic; afull tied 1'b0.
// STRUCTURE
//  - Package corefifo_pkg: function bin2gray, function gray2bin (parametric width),
//    localparam PTRW = ADDRWIDTH+1, DEPTH = 1<<ADDRWIDTH.
//  - Sub-module corefifo_gray2bin (XOR prefix chain, combinational), instantiated
//    only under COREFIFO_AFULL_EN.
//  - Everything else (counter, Gray register, flags) in this module.
// TESTING (ADDRWIDTH=3, AFULL_VAL=6, rptr_gray_s held 0 unless stated)
//  1 arstn low mid-stream -> all outputs 0 immediately, waddr=0; release -> idle.
//  2 8 consecutive wr_en -> waddr 0..7, wptr_gray 1,3,2,6,7,5,4,C; full=1 after 8th;
//    8 wr_ack pulses.
//  3 Continue wr_en while full -> we_ram=0, overflow pulses, wbin stays 8, no ack.
//  4 While full drive rptr_gray_s=1 -> full=0 next cycle; one write accepted
//    (waddr=0), full=1 again.
//  5 Wrap: cycle 16 writes with rptr_gray_s tracking 2 words behind -> wbin wraps
//    15->0, full never asserts, wptr_gray single-bit changes checked each cycle.
//  6 COREFIFO_AFULL_EN: afull=1 after 6th write, 0 after 5th; without macro afull=0.
//    srstn low one cycle at wbin=5 -> all cleared next edge, wr_en that cycle ignored.

Source files
------------

// File: rtl/corefifo_pkg.sv
// Shared definitions for the COREFIFO write-side pointer logic.
// Holds the default geometry and the Gray <-> binary helpers used by the
// pointer generator and by the read-pointer decoder.
package corefifo_pkg;

    localparam int ADDRWIDTH_DEF = 3;
    localparam int PTRW          = ADDRWIDTH_DEF + 1;
    localparam int DEPTH         = 1 << ADDRWIDTH_DEF;

    // Binary to reflected Gray. This works at any width up to 32 because
    // unused upper bits stay zero.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary. Each binary bit is the XOR of all Gray bits at or
    // above it. Zero upper bits make this correct at any width up to 32.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/corefifo_gray2bin.sv
// Combinational Gray-to-binary decoder (XOR prefix chain from the MSB down).
// The top level uses it only when COREFIFO_AFULL_EN is defined, to turn the
// synchronized read pointer into a binary count operand.
module corefifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each bin_o bit is the reduction XOR of the Gray bits from the MSB down
    // to that bit position.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign bin_o[gi] = ^gray_i[W-1:gi];
    end

endmodule

// File: rtl/corefifo_wr_ptr_gen.sv
// Write-domain pointer generator for the dual-clock COREFIFO.
//
// The module keeps the binary write counter (wbin). It launches a registered
// Gray copy of that counter toward the read-domain synchronizer. It compares
// that copy against the synchronized read pointer to produce a registered full
// flag.
//
// Optional feature: define COREFIFO_AFULL_EN to build the almost-full flag.
// Without the macro, afull is tied low and no decoder or subtractor is built.
module corefifo_wr_ptr_gen
    import corefifo_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int AFULL_VAL = 6
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 srstn,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH:0]   rptr_gray_s,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic [ADDRWIDTH:0]   wptr_gray,
    output logic                 we_ram,
    output logic                 full,
    output logic                 afull,
    output logic                 wr_ack,
    output logic                 overflow
);

    localparam int PTR_W = ADDRWIDTH + 1;
    localparam int A     = ADDRWIDTH;

    logic [PTR_W-1:0] wbin_q;
    logic [PTR_W-1:0] wbin_d;
    logic [PTR_W-1:0] wgray_q;
    logic [PTR_W-1:0] wgray_d;
    logic [PTR_W-1:0] full_pattern;
    logic             full_q;
    logic             full_d;
    logic             wr_ack_q;
    logic             overflow_q;

    // A write is accepted only when the registered full flag is clear, so
    // a write that arrives in the same cycle the reader frees space is still
    // rejected.
    assign we_ram = wr_en & ~full_q;
    assign waddr  = wbin_q[ADDRWIDTH-1:0];

    // The next binary pointer wraps naturally at 2**PTR_W. Its Gray form is
    // what the launch register will hold next.
    assign wbin_d  = wbin_q + {{(PTR_W-1){1'b0}}, we_ram};
    assign wgray_d = PTR_W'(bin2gray(32'(wbin_d)));

    // The FIFO is full when the write pointer is exactly one lap ahead of the
    // read pointer. In Gray code, that means the top two bits are inverted and
    // the remaining bits are equal.
    assign full_pattern = {~rptr_gray_s[A:A-1], rptr_gray_s[A-2:0]};
    assign full_d       = (wgray_d == full_pattern);

    // Counter, Gray launch register and status flags. The synchronous reset
    // takes priority over any write in the same cycle.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            full_q     <= 1'b0;
            wr_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (!srstn) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            full_q     <= 1'b0;
            wr_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            full_q     <= full_d;
            wr_ack_q   <= we_ram;
            overflow_q <= wr_en & full_q;
        end
    end

    assign wptr_gray = wgray_q;
    assign full      = full_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;

`ifdef COREFIFO_AFULL_EN
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] wcnt;
    logic             afull_q;
    logic             afull_d;

    corefifo_gray2bin #(
        .W      (PTR_W)
    ) u_rptr_g2b (
        .gray_i (rptr_gray_s),
        .bin_o  (rbin)
    );

    // The occupancy is computed modulo 2**PTR_W. It uses the post-write
    // pointer, so afull rises in the same cycle as full or earlier.
    assign wcnt    = wbin_d - rbin;
    assign afull_d = (wcnt >= PTR_W'(AFULL_VAL));

    // Register the almost-full flag, using the same reset scheme as the main
    // flags.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            afull_q <= 1'b0;
        end else if (!srstn) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign afull = afull_q;
`else
    assign afull = 1'b0;
`endif

endmodule
